// File: rtl/pixel_point_stream.sv
// Streaming RGB point-operation engine: tracks frame position and applies a per-frame mode.
// Two-stage pipeline; a stalled output (m_valid & ~m_ready) freezes every stage and drops s_ready.
module pixel_point_stream #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int DW     = 8,
  parameter int COL_W  = 11,
  parameter int ROW_W  = 10
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [2:0]    cfg_mode,
  input  logic [DW-1:0] cfg_value,
  input  logic [DW-1:0] cfg_threshold,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_r,
  input  logic [DW-1:0] s_g,
  input  logic [DW-1:0] s_b,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_r,
  output logic [DW-1:0] m_g,
  output logic [DW-1:0] m_b,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output logic          frame_done,
  output logic          busy
);

  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;
  localparam logic [DW-1:0] MAX     = '1;

  logic [0:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [2:0]       mode_sh;
  logic [DW-1:0]    val_sh, thr_sh;

  logic adv, accept, at_sof, at_eol, at_eof;

  assign adv     = ~m_valid | m_ready;
  assign s_ready = adv & HRESETn;
  assign accept  = s_valid & s_ready;
  assign at_sof  = (col == '0) && (row == '0);
  assign at_eol  = (col == COL_W'(WIDTH - 1));
  assign at_eof  = at_eol && (row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      col     <= '0;
      row     <= '0;
      mode_sh <= '0;
      val_sh  <= '0;
      thr_sh  <= '0;
    end else if (accept) begin
      if (at_sof) begin
        mode_sh <= cfg_mode;
        val_sh  <= cfg_value;
        thr_sh  <= cfg_threshold;
      end
      if (at_eol) begin
        col <= '0;
        row <= at_eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      case (state)
        ST_IDLE: state <= ST_RUN;
        default: state <= at_eof ? ST_IDLE : ST_RUN;
      endcase
    end
  end

  // Stage 1: channels, channel sum and the frame's config travel together with the pixel,
  // so a new frame entering behind the previous eof never sees the wrong settings.
  logic          valid1, sof1, eol1, eof1;
  logic [DW-1:0] r1, g1, b1, val1, thr1;
  logic [DW+1:0] sum1;
  logic [2:0]    mode1;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      valid1 <= 1'b0;
      sof1   <= 1'b0;
      eol1   <= 1'b0;
      eof1   <= 1'b0;
      r1     <= '0;
      g1     <= '0;
      b1     <= '0;
      sum1   <= '0;
      mode1  <= '0;
      val1   <= '0;
      thr1   <= '0;
    end else if (adv) begin
      valid1 <= s_valid;
      sof1   <= s_valid & at_sof;
      eol1   <= s_valid & at_eol;
      eof1   <= s_valid & at_eof;
      r1     <= s_r;
      g1     <= s_g;
      b1     <= s_b;
      sum1   <= (DW+2)'(s_r) + (DW+2)'(s_g) + (DW+2)'(s_b);
      mode1  <= at_sof ? cfg_mode      : mode_sh;
      val1   <= at_sof ? cfg_value     : val_sh;
      thr1   <= at_sof ? cfg_threshold : thr_sh;
    end
  end

  function automatic logic [DW-1:0] chan_op(input logic [2:0] mode, input logic [DW-1:0] x,
                                            input logic [DW-1:0] val, input logic [DW-1:0] gray,
                                            input logic thr_hit);
    logic [DW:0] add;
    add = {1'b0, x} + {1'b0, val};
    case (mode)
      3'd1:    chan_op = add[DW] ? MAX : add[DW-1:0];
      3'd2:    chan_op = (x >= val) ? x - val : '0;
      3'd3:    chan_op = MAX - x;
      3'd4:    chan_op = thr_hit ? MAX : '0;
      3'd5:    chan_op = gray;
      default: chan_op = x;
    endcase
  endfunction

  logic [DW-1:0] gray;
  logic          thr_hit;

  // The quotient of a DW+2 bit sum by 3 always fits in DW bits.
  assign gray    = DW'(sum1 / (DW+2)'(3));
  assign thr_hit = gray > thr1;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      m_valid    <= 1'b0;
      m_r        <= '0;
      m_g        <= '0;
      m_b        <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_eof      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid & m_ready & m_eof;
      if (adv) begin
        m_valid <= valid1;
        m_r     <= chan_op(mode1, r1, val1, gray, thr_hit);
        m_g     <= chan_op(mode1, g1, val1, gray, thr_hit);
        m_b     <= chan_op(mode1, b1, val1, gray, thr_hit);
        m_sof   <= valid1 & sof1;
        m_eol   <= valid1 & eol1;
        m_eof   <= valid1 & eof1;
      end
    end
  end

  assign busy = (state == ST_RUN) | valid1 | m_valid;

endmodule

// File: tb/tb_pixel_point_stream.sv
// Scoreboard bench for pixel_point_stream on a 4x2 frame with 8-bit channels.
module tb_pixel_point_stream;
  localparam int W = 4, H = 2, NPIX = W * H;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [2:0] cfg_mode;
  logic [7:0] cfg_value, cfg_threshold;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_r, s_g, s_b, m_r, m_g, m_b;
  logic       m_sof, m_eol, m_eof, frame_done, busy;

  always #5 HCLK = ~HCLK;

  pixel_point_stream #(.WIDTH(W), .HEIGHT(H), .DW(8), .COL_W(2), .ROW_W(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cfg_mode(cfg_mode), .cfg_value(cfg_value),
    .cfg_threshold(cfg_threshold), .s_valid(s_valid), .s_ready(s_ready),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .m_valid(m_valid), .m_ready(m_ready),
    .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic [2:0] flags;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0, fd_count = 0;
  int   pidx = 0, sh_mode = 0, sh_val = 0, sh_thr = 0, stall_cnt = 0;
  bit   bp_rand = 1'b0, lat_chk = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_ch(int mode, int x, int val, int sum, int thr);
    int gray;
    gray = sum / 3;
    case (mode)
      1:       return (x + val > 255) ? 255 : x + val;
      2:       return (x >= val) ? x - val : 0;
      3:       return 255 - x;
      4:       return (gray > thr) ? 255 : 0;
      5:       return gray;
      default: return x;
    endcase
  endfunction

  // Reference: config snapshot at frame start, position from a running pixel index.
  task automatic model_accept(input int r, input int g, input int b);
    exp_t e;
    if (pidx == 0) begin
      sh_mode = cfg_mode; sh_val = cfg_value; sh_thr = cfg_threshold;
    end
    e.r     = 8'(ref_ch(sh_mode, r, sh_val, r + g + b, sh_thr));
    e.g     = 8'(ref_ch(sh_mode, g, sh_val, r + g + b, sh_thr));
    e.b     = 8'(ref_ch(sh_mode, b, sh_val, r + g + b, sh_thr));
    e.flags = {pidx == 0, (pidx % W) == W - 1, pidx == NPIX - 1};
    e.acc   = cyc;
    e.lat   = lat_chk;
    q.push_back(e);
    pidx = (pidx + 1) % NPIX;
  endtask

  task automatic tick(input bit v, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, output bit acc);
    @(negedge HCLK);
    s_valid = v; s_r = r; s_g = g; s_b = b;
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    acc = HRESETn && v && s_ready;
    if (acc) model_accept(r, g, b);
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, 8'h00, a);
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit a;
    int n;
    n = 0;
    do begin
      tick(1'b1, r, g, b, a);
      n++;
    end while (!a && n < 100);
    if (!a) chk("send_timeout", 1, 0);
  endtask

  task automatic send_list(input logic [23:0] px[NPIX]);
    for (int i = 0; i < NPIX; i++) send_pixel(px[i][23:16], px[i][15:8], px[i][7:0]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge HCLK);
    HRESETn = 1'b0;
    s_valid = 1'b0;
    q.delete();
    pidx = 0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    repeat (ncyc) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    chk("rst_outputs", {m_valid, m_r, m_g, m_b, m_sof, m_eol, m_eof, frame_done}, 0);
    chk("rst_busy", busy, 0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks holds during stalls.
  bit         fd_exp = 1'b0, hold = 1'b0;
  logic [7:0] hr, hg, hb;
  logic [2:0] hf;
  exp_t       me;

  always @(negedge HCLK) begin
    #2;
    if (!HRESETn) begin
      fd_exp = 1'b0;
      hold   = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      if (frame_done) fd_count++;
      if (hold) chk("stall_hold", {m_valid, m_r, m_g, m_b, m_sof, m_eol, m_eof},
                    {1'b1, hr, hg, hb, hf});
      if (m_valid && !m_ready) chk("stall_s_ready", s_ready, 0);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          me = q.pop_front();
          chk("out_rgb", {m_r, m_g, m_b}, {me.r, me.g, me.b});
          chk("out_flags", {m_sof, m_eol, m_eof}, me.flags);
          if (me.lat) chk("latency", cyc - me.acc, 2);
        end
      end
      fd_exp = m_valid && m_ready && m_eof;
      hold   = m_valid && !m_ready;
      hr = m_r; hg = m_g; hb = m_b; hf = {m_sof, m_eol, m_eof};
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [23:0] px[NPIX];
    int fd0;
    HRESETn = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    s_r = '0; s_g = '0; s_b = '0;
    cfg_mode = 3'd0; cfg_value = '0; cfg_threshold = '0;
    do_reset(2);

    // Bypass ramp with latency and frame_done checks
    fd0 = fd_count;
    lat_chk = 1'b1;
    for (int i = 0; i < NPIX; i++) send_pixel(8'(i), 8'(i + 10), 8'(i + 20));
    lat_chk = 1'b0;
    drain();
    idle(2);
    chk("ramp_frame_done", fd_count, fd0 + 1);
    chk("ramp_busy_low", busy, 0);

    cfg_mode = 3'd1; cfg_value = 8'd100;
    px = '{24'hC8_0A_0A, 24'h64_9B_9C, 24'h00_FF_01, 24'h9B_9C_9D,
           24'h9C_00_FF, 24'hFF_64_63, 24'h01_02_03, 24'h63_C8_65};
    send_list(px);
    cfg_mode = 3'd2;
    px = '{24'h32_96_64, 24'h96_32_00, 24'h64_63_65, 24'h63_FF_01,
           24'h65_64_00, 24'h00_01_02, 24'hFF_FE_10, 24'h07_08_09};
    send_list(px);
    cfg_mode = 3'd4; cfg_threshold = 8'd90;
    px = '{24'h5A_5A_5C, 24'h5B_5B_5B, 24'h5A_5A_5A, 24'h00_00_00,
           24'hFF_FF_FF, 24'h59_5A_5B, 24'h5A_5B_5C, 24'h10_F0_20};
    send_list(px);
    cfg_mode = 3'd5;
    px = '{24'h0A_14_1F, 24'hFF_FF_FF, 24'h00_00_01, 24'h01_01_01,
           24'hFF_FF_FE, 24'h11_22_33, 24'h80_00_00, 24'h00_00_00};
    send_list(px);
    cfg_mode = 3'd3;
    px = '{24'h0F_0F_0F, 24'h00_FF_80, 24'h12_34_56, 24'hF0_0F_AA,
           24'h01_02_03, 24'hFE_FD_FC, 24'h55_AA_55, 24'h7F_80_81};
    send_list(px);
    drain();

    // Backpressure: 5-cycle stall mid-frame while the source keeps offering
    cfg_mode = 3'd1; cfg_value = 8'd7;
    for (int i = 0; i < NPIX; i++) begin
      if (i == 3) stall_cnt = 5;
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    end
    drain();

    // Mode change mid-frame, then back-to-back frame B
    cfg_mode = 3'd1; cfg_value = 8'd30;
    for (int i = 0; i < 2 * NPIX; i++) begin
      if (i == 2) cfg_mode = 3'd3;
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    end
    drain();

    // Random traffic, random config churn and random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 6 * NPIX; i++) begin
      cfg_mode = 3'($urandom); cfg_value = 8'($urandom); cfg_threshold = 8'($urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    end
    drain();
    bp_rand = 1'b0;

    // Reset mid-frame, then a clean frame
    cfg_mode = 3'd0;
    for (int i = 0; i < 3; i++) send_pixel(8'(i + 1), 8'(i + 2), 8'(i + 3));
    do_reset(1);
    fd0 = fd_count;
    for (int i = 0; i < NPIX; i++) send_pixel(8'($urandom), 8'($urandom), 8'($urandom));
    drain();
    idle(2);
    chk("post_reset_frame_done", fd_count, fd0 + 1);
    chk("post_reset_busy_low", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
